// File: rtl/recovery_request_arbiter_if.sv
// Recovery request bus: commit/RW requests in, issue pulses and held request out.
// Ports: master = request producer / recovery manager side, slave = arbiter side.
interface recovery_request_arbiter_if #(
   parameter int NUM_RW_LANES = 2,
   parameter int AL_IDX_W     = 6,
   parameter int PC_W         = 32,
   parameter int RT_W         = 3,
   parameter int CNT_W        = 8
);
   logic                         cmReq;
   logic [RT_W-1:0]              cmRefetchType;
   logic [PC_W-1:0]              cmPC;
   logic [AL_IDX_W-1:0]          cmOpPtr;
   logic [NUM_RW_LANES-1:0]      rwReq;
   logic [NUM_RW_LANES*RT_W-1:0] rwRefetchType;
   logic [NUM_RW_LANES*PC_W-1:0] rwPC;
   logic [NUM_RW_LANES*AL_IDX_W-1:0] rwOpPtr;
   logic [AL_IDX_W-1:0]          alHeadPtr;
   logic                         phaseIsCommit;
   logic                         unableToStartRecovery;
   logic                         exceptionDetectedInCommitStage;
   logic                         exceptionDetectedInRwStage;
   logic [RT_W-1:0]              refetchTypeOut;
   logic [PC_W-1:0]              recoveredPC;
   logic [AL_IDX_W-1:0]          exceptionOpPtr;
   logic                         busy;
   logic [CNT_W-1:0]             dropCount;

   modport master (
      output cmReq, cmRefetchType, cmPC, cmOpPtr,
      output rwReq, rwRefetchType, rwPC, rwOpPtr,
      output alHeadPtr, phaseIsCommit, unableToStartRecovery,
      input  exceptionDetectedInCommitStage, exceptionDetectedInRwStage,
      input  refetchTypeOut, recoveredPC, exceptionOpPtr, busy, dropCount
   );

   modport slave (
      input  cmReq, cmRefetchType, cmPC, cmOpPtr,
      input  rwReq, rwRefetchType, rwPC, rwOpPtr,
      input  alHeadPtr, phaseIsCommit, unableToStartRecovery,
      output exceptionDetectedInCommitStage, exceptionDetectedInRwStage,
      output refetchTypeOut, recoveredPC, exceptionOpPtr, busy, dropCount
   );
endinterface

// File: rtl/recovery_request_arbiter.sv
// Picks the oldest recovery request (commit or RW lanes), holds it until the
// recovery manager can start, issues a one-cycle pulse, counts dropped requests.
// Ports: clk, rst (async active-low), bus (slave modport of the request bus).
module recovery_request_arbiter #(
   parameter int NUM_RW_LANES = 2,
   parameter int AL_IDX_W     = 6,
   parameter int PC_W         = 32,
   parameter int RT_W         = 3,
   parameter int CNT_W        = 8
) (
   input logic                   clk,
   input logic                   rst,
   recovery_request_arbiter_if.slave bus
);
   localparam int DW = $clog2(NUM_RW_LANES + 2);
   localparam int SW = CNT_W + DW + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {IDLE, HOLD, ISSUED} state_e;

   state_e              state_q, state_d;
   logic                flag_q, flag_d;
   logic                hold_cm_q, hold_cm_d;
   logic [RT_W-1:0]     hold_rt_q, hold_rt_d;
   logic [PC_W-1:0]     hold_pc_q, hold_pc_d;
   logic [AL_IDX_W-1:0] hold_ptr_q, hold_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                win_vld;
   logic                win_cm;
   logic [RT_W-1:0]     win_rt;
   logic [PC_W-1:0]     win_pc;
   logic [AL_IDX_W-1:0] win_ptr;
   logic [AL_IDX_W-1:0] win_age;
   logic [AL_IDX_W-1:0] lane_ptr;
   logic [AL_IDX_W-1:0] lane_age;
   logic [AL_IDX_W-1:0] hold_age;
   logic [DW-1:0]       nreq;
   logic [DW-1:0]       drops;
   logic [SW-1:0]       sum;
   logic                issue_cm;
   logic                issue_rw;

   // Age is distance from the ActiveList head; modular subtraction handles wrap.
   assign hold_age = hold_ptr_q - bus.alHeadPtr;

   // Oldest-first; strict compare keeps ties with commit, then the lowest lane.
   always_comb begin
      win_vld  = bus.cmReq;
      win_cm   = 1'b1;
      win_rt   = bus.cmRefetchType;
      win_pc   = bus.cmPC;
      win_ptr  = bus.cmOpPtr;
      win_age  = bus.cmOpPtr - bus.alHeadPtr;
      nreq     = DW'(bus.cmReq);
      lane_ptr = '0;
      lane_age = '0;
      for (int i = 0; i < NUM_RW_LANES; i++) begin
         lane_ptr = bus.rwOpPtr[i*AL_IDX_W +: AL_IDX_W];
         lane_age = lane_ptr - bus.alHeadPtr;
         if (bus.rwReq[i]) begin
            nreq = nreq + DW'(1);
            if (!win_vld || (lane_age < win_age)) begin
               win_vld = 1'b1;
               win_cm  = 1'b0;
               win_rt  = bus.rwRefetchType[i*RT_W +: RT_W];
               win_pc  = bus.rwPC[i*PC_W +: PC_W];
               win_ptr = lane_ptr;
               win_age = lane_age;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      flag_d     = flag_q;
      hold_cm_d  = hold_cm_q;
      hold_rt_d  = hold_rt_q;
      hold_pc_d  = hold_pc_q;
      hold_ptr_d = hold_ptr_q;
      drops      = '0;
      issue_cm   = 1'b0;
      issue_rw   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               hold_cm_d  = win_cm;
               hold_rt_d  = win_rt;
               hold_pc_d  = win_pc;
               hold_ptr_d = win_ptr;
               drops      = nreq - DW'(1);
               state_d    = HOLD;
            end
         end
         HOLD: begin
            // Issuing wins over replacement: arrivals this cycle are dropped.
            if (bus.phaseIsCommit && !bus.unableToStartRecovery) begin
               issue_cm = hold_cm_q;
               issue_rw = !hold_cm_q;
               drops    = nreq;
               flag_d   = 1'b0;
               state_d  = ISSUED;
            end else if (win_vld && (win_age < hold_age)) begin
               // Winner captured, old held request dropped: net drops = nreq.
               hold_cm_d  = win_cm;
               hold_rt_d  = win_rt;
               hold_pc_d  = win_pc;
               hold_ptr_d = win_ptr;
               drops      = nreq;
            end else begin
               drops = nreq;
            end
         end
         ISSUED: begin
            drops = nreq;
            // Wait for the manager to leave and re-enter the commit phase.
            if (bus.phaseIsCommit && flag_q) begin
               flag_d  = 1'b0;
               state_d = IDLE;
            end else if (!bus.phaseIsCommit) begin
               flag_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sum   = SW'(cnt_q) + SW'(drops);
      cnt_d = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         flag_q     <= 1'b0;
         hold_cm_q  <= 1'b0;
         hold_rt_q  <= '0;
         hold_pc_q  <= '0;
         hold_ptr_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         flag_q     <= flag_d;
         hold_cm_q  <= hold_cm_d;
         hold_rt_q  <= hold_rt_d;
         hold_pc_q  <= hold_pc_d;
         hold_ptr_q <= hold_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.exceptionDetectedInCommitStage = issue_cm;
   assign bus.exceptionDetectedInRwStage     = issue_rw;
   assign bus.refetchTypeOut                 = hold_rt_q;
   assign bus.recoveredPC                    = hold_pc_q;
   assign bus.exceptionOpPtr                 = hold_ptr_q;
   assign bus.busy                           = (state_q != IDLE);
   assign bus.dropCount                      = cnt_q;
endmodule
